toggle_event_decoder: RTL and testbench
=======================================

# toggle_event_decoder

Receive-side decoder for toggle-encoded event links driven by a T flip-flop: every level change on the incoming toggle line is one event. The block detects each transition, queues events in a saturating pending counter and presents them one at a time on a valid/ready handshake. It also keeps a free-running total count and a sticky overflow flag. It sits at the receiving end of any single-wire event link in the flip-flop library.

## Interface
- CNT_W, 4: pending-counter width. Maximum queued events is 2^CNT_W-1.
- TOTAL_W, 16: width of the total detected-event counter.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- t_in  input  1  toggle-encoded event line; each 0->1 or 1->0 change is one event.
- ev_ready  input  1  consumer accepts the presented event.
- clr_ovf  input  1  clears the sticky overflow flag.
- ev_valid  output  1  at least one event is pending.
- pending  output  CNT_W  number of queued, unconsumed events.
- total  output  TOTAL_W  count of all detected toggles, modulo 2^TOTAL_W.
- overflow  output  1  sticky; an event was dropped because pending was full.

## Operation
- Level tracking register t_prev holds the last sampled line level (t_s). Toggle detect: tog = t_s ^ t_prev.
- Without the synchronizer, t_s = t_in.
- During reset, t_prev (and the synchronizer stages, when present) keep loading the line level. On reset release, the current level is the baseline and no spurious event is generated.
- Reset values: pending=0, ev_valid=0, total=0, overflow=0.
- Pop: a pop occurs when ev_valid && ev_ready.
- Push: a push occurs when tog=1.
- Pending update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged
  - neither: unchanged
- Full: pending = 2^CNT_W-1, push and no pop:
  - pending holds its value
  - overflow is set
  - total still increments
- Empty: ev_ready while pending=0 has no effect. Pending never underflows.
- ev_valid = (pending != 0), derived from registered state only. It has no combinational path from ev_ready or t_in.
- total increments on every tog, regardless of full. It wraps from 2^TOTAL_W-1 to 0.
- clr_ovf clears overflow. If an overflow event happens in the same cycle, set wins and overflow stays 1.
- Reset asserted mid-operation discards all queued events and counts on that edge.

## Timing
- Without the macro: t_in changes before edge k -> pending/total update at edge k. ev_valid is high after edge k (1-cycle latency).
- With the macro: the same update happens at edge k+2 (3-cycle latency).
- Back-to-back toggles on consecutive cycles are each counted. There is 1 event per cycle maximum.
- Reset must be held at least 1 cycle without the macro, or at least 3 cycles with it, to establish the baseline.
- Handshake:
  - ev_valid, once high, stays high until the pop that takes pending to 0.
  - A pop retires exactly one event per cycle.

## Configuration
- TOGGLE_EVENT_DECODER_SYNC_EN defined: t_s is taken from a 2-flop synchronizer on t_in, so t_in may be asynchronous to clk. Latency is 3 cycles and the minimum reset is 3 cycles.
- TOGGLE_EVENT_DECODER_SYNC_EN not defined: t_in is sampled directly and must be synchronous to clk. Latency is 1 cycle and there is no synchronizer logic.

## Test plan
- Baseline: hold t_in=1 during a 3-cycle reset, release, keep t_in=1 for 10 cycles -> pending=0, ev_valid=0, total=0 throughout.
- Single event: from t_in=0 with ev_ready=0, toggle t_in once -> pending=1 and ev_valid=1 after 1 cycle (3 with macro), total=1. Then assert ev_ready for 1 cycle -> pending=0, ev_valid=0.
- Burst and drain: toggle t_in on 5 consecutive cycles with ev_ready=0 -> pending=5, total=5. Then hold ev_ready=1 -> pending goes 4,3,2,1,0, one step per cycle.
- Overflow: CNT_W=4, ev_ready=0, 17 toggles -> pending saturates at 15, overflow=1, total=17. clr_ovf pulsed alone -> overflow=0. clr_ovf with a simultaneous dropped toggle -> overflow stays 1.
- Simultaneous push/pop: with pending=3, toggle t_in and assert ev_ready in the same cycle -> pending stays 3, total +1.
- Wrap and reset: TOTAL_W=4, 16 toggles with ev_ready=1 -> total=0, pending=0. Then assert reset with pending=2 and overflow=1 -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/toggle_event_decoder_if.sv
// ---------------------------------------------------------------------------
// toggle_event_decoder_if
// Groups the event-link and handshake signals of toggle_event_decoder.
//   t_in     : toggle-encoded event line (driven by the link side)
//   ev_ready : consumer accepts the presented event
//   clr_ovf  : clears the sticky overflow flag
//   ev_valid : at least one event is pending
//   pending  : number of queued, unconsumed events (CNT_W bits)
//   total    : running count of detected toggles, modulo 2^TOTAL_W
//   overflow : sticky, an event was dropped because pending was full
// Modports: master drives the inputs and observes the outputs;
//           slave is the decoder side.
// ---------------------------------------------------------------------------
interface toggle_event_decoder_if #(
    parameter int CNT_W   = 4,
    parameter int TOTAL_W = 16
);
    logic               t_in;
    logic               ev_ready;
    logic               clr_ovf;
    logic               ev_valid;
    logic [CNT_W-1:0]   pending;
    logic [TOTAL_W-1:0] total;
    logic               overflow;

    modport master (
        output t_in, ev_ready, clr_ovf,
        input  ev_valid, pending, total, overflow
    );

    modport slave (
        input  t_in, ev_ready, clr_ovf,
        output ev_valid, pending, total, overflow
    );
endinterface

// File: rtl/toggle_event_decoder.sv
// ---------------------------------------------------------------------------
// toggle_event_decoder
// Receive-side decoder for a toggle-encoded event link. Every level change on
// t_in is one event. Events are queued in a saturating pending counter and
// handed out one per cycle on a valid/ready handshake. A free-running total
// counter and a sticky overflow flag are kept alongside.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : toggle_event_decoder_if.slave (t_in, ev_ready, clr_ovf in;
//            ev_valid, pending, total, overflow out)
//
// Optional feature macro: TOGGLE_EVENT_DECODER_SYNC_EN
//   defined     -> t_in passes through a 2-flop synchronizer (may be async to
//                  clk); event latency 3 cycles, reset must last >= 3 cycles.
//   not defined -> t_in sampled directly (must be synchronous); latency 1.
// ---------------------------------------------------------------------------
module toggle_event_decoder #(
    parameter int CNT_W   = 4,
    parameter int TOTAL_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    toggle_event_decoder_if.slave     bus
);

    logic               w_t_s;
    logic               r_t_prev;
    logic [CNT_W-1:0]   r_pending;
    logic [TOTAL_W-1:0] r_total;
    logic               r_overflow;

    logic               w_tog;
    logic               w_pop;
    logic               w_full;

`ifdef TOGGLE_EVENT_DECODER_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // The synchronizer is deliberately not reset: it keeps tracking the line
    // during reset so the baseline level is in place on release.
    always_ff @(posedge clk) begin
        r_sync1 <= bus.t_in;
        r_sync2 <= r_sync1;
    end

    assign w_t_s = r_sync2;
`else
    assign w_t_s = bus.t_in;
`endif

    // Level tracker also loads during reset, so the level present at release
    // becomes the baseline and produces no spurious event.
    always_ff @(posedge clk) begin
        r_t_prev <= w_t_s;
    end

    assign w_tog  = w_t_s ^ r_t_prev;
    assign w_pop  = (r_pending != '0) && bus.ev_ready;
    assign w_full = &r_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= '0;
            r_total    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Push and pop together leave the count unchanged; a push into a
            // full counter with no pop is dropped.
            if (w_tog && !w_pop && !w_full) begin
                r_pending <= r_pending + CNT_W'(1);
            end else if (w_pop && !w_tog) begin
                r_pending <= r_pending - CNT_W'(1);
            end

            r_total <= r_total + TOTAL_W'(w_tog);

            // Set takes priority over clear when both happen in one cycle.
            if (w_tog && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.ev_valid = (r_pending != '0);
    assign bus.pending  = r_pending;
    assign bus.total    = r_total;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_toggle_event_decoder.sv
module tb_toggle_event_decoder;

    localparam int CNT_W   = 4;
    localparam int TOTAL_W = 4;
`ifdef TOGGLE_EVENT_DECODER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    toggle_event_decoder_if #(.CNT_W(CNT_W), .TOTAL_W(TOTAL_W)) bus ();

    toggle_event_decoder #(.CNT_W(CNT_W), .TOTAL_W(TOTAL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic level);
        reset        = 1'b1;
        bus.t_in     = level;
        bus.ev_ready = 1'b0;
        bus.clr_ovf  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    // n back-to-back toggles, one per cycle, then wait out the input pipeline
    task automatic toggles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.t_in = ~bus.t_in;
            tick();
        end
        repeat (LAT - 1) tick();
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.pending !== 4'd0 || bus.ev_valid !== 1'b0 || bus.total !== 4'd0) begin
                $display("FAIL baseline cyc=%0d pending=%0d valid=%0b total=%0d required 0/0/0",
                         i, bus.pending, bus.ev_valid, bus.total);
                failures++;
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset(1'b0);
        bus.t_in = 1'b1;
        checks++;
        if (bus.pending !== 4'd0) begin
            $display("FAIL single_early pending=%0d required 0", bus.pending);
            failures++;
        end
        repeat (LAT) tick();
        checks++;
        if (bus.pending !== 4'd1 || bus.ev_valid !== 1'b1 || bus.total !== 4'd1) begin
            $display("FAIL single_push pending=%0d valid=%0b total=%0d required 1/1/1",
                     bus.pending, bus.ev_valid, bus.total);
            failures++;
        end
        bus.ev_ready = 1'b1;
        tick();
        bus.ev_ready = 1'b0;
        checks++;
        if (bus.pending !== 4'd0 || bus.ev_valid !== 1'b0) begin
            $display("FAIL single_pop pending=%0d valid=%0b required 0/0",
                     bus.pending, bus.ev_valid);
            failures++;
        end
        $display("test_single done");
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        toggles(5);
        checks++;
        if (bus.pending !== 4'd5 || bus.total !== 4'd5 || bus.ev_valid !== 1'b1) begin
            $display("FAIL burst pending=%0d total=%0d valid=%0b required 5/5/1",
                     bus.pending, bus.total, bus.ev_valid);
            failures++;
        end
        bus.ev_ready = 1'b1;
        for (int exp = 4; exp >= 0; exp--) begin
            tick();
            checks++;
            if (bus.pending !== 4'(exp) || bus.ev_valid !== (exp != 0)) begin
                $display("FAIL drain pending=%0d valid=%0b required %0d", bus.pending,
                         bus.ev_valid, exp);
                failures++;
            end
        end
        tick();  // ev_ready on an empty queue must not underflow
        bus.ev_ready = 1'b0;
        checks++;
        if (bus.pending !== 4'd0 || bus.total !== 4'd5) begin
            $display("FAIL empty_pop pending=%0d total=%0d required 0/5",
                     bus.pending, bus.total);
            failures++;
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_overflow();
        do_reset(1'b0);
        toggles(17);
        checks++;
        if (bus.pending !== 4'd15 || bus.overflow !== 1'b1 || bus.total !== 4'd1) begin
            $display("FAIL ovf_sat pending=%0d ovf=%0b total=%0d required 15/1/1",
                     bus.pending, bus.overflow, bus.total);
            failures++;
        end
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0 || bus.pending !== 4'd15) begin
            $display("FAIL ovf_clr ovf=%0b pending=%0d required 0/15",
                     bus.overflow, bus.pending);
            failures++;
        end
        // Dropped toggle lands on the same edge as clr_ovf
        bus.t_in = ~bus.t_in;
        repeat (LAT - 1) tick();
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        checks++;
        if (bus.overflow !== 1'b1 || bus.pending !== 4'd15 || bus.total !== 4'd2) begin
            $display("FAIL ovf_set_wins ovf=%0b pending=%0d total=%0d required 1/15/2",
                     bus.overflow, bus.pending, bus.total);
            failures++;
        end
        $display("test_overflow done");
    endtask

    task automatic test_push_pop();
        do_reset(1'b1);
        toggles(3);
        checks++;
        if (bus.pending !== 4'd3) begin
            $display("FAIL pp_setup pending=%0d required 3", bus.pending);
            failures++;
        end
        bus.t_in = ~bus.t_in;
        repeat (LAT - 1) tick();
        bus.ev_ready = 1'b1;
        tick();
        bus.ev_ready = 1'b0;
        checks++;
        if (bus.pending !== 4'd3 || bus.total !== 4'd4) begin
            $display("FAIL push_pop pending=%0d total=%0d required 3/4",
                     bus.pending, bus.total);
            failures++;
        end
        $display("test_push_pop done");
    endtask

    task automatic test_wrap_reset();
        do_reset(1'b0);
        bus.ev_ready = 1'b1;
        toggles(16);
        tick();
        checks++;
        if (bus.total !== 4'd0 || bus.pending !== 4'd0 || bus.overflow !== 1'b0) begin
            $display("FAIL wrap total=%0d pending=%0d ovf=%0b required 0/0/0",
                     bus.total, bus.pending, bus.overflow);
            failures++;
        end
        bus.ev_ready = 1'b0;
        toggles(17);
        bus.ev_ready = 1'b1;
        repeat (13) tick();
        bus.ev_ready = 1'b0;
        checks++;
        if (bus.pending !== 4'd2 || bus.overflow !== 1'b1 || bus.total !== 4'd1) begin
            $display("FAIL pre_reset pending=%0d ovf=%0b total=%0d required 2/1/1",
                     bus.pending, bus.overflow, bus.total);
            failures++;
        end
        reset = 1'b1;
        tick();
        checks++;
        if (bus.pending !== 4'd0 || bus.ev_valid !== 1'b0 || bus.total !== 4'd0 ||
            bus.overflow !== 1'b0) begin
            $display("FAIL mid_reset pending=%0d valid=%0b total=%0d ovf=%0b required all 0",
                     bus.pending, bus.ev_valid, bus.total, bus.overflow);
            failures++;
        end
        repeat (2) tick();
        reset = 1'b0;
        $display("test_wrap_reset done");
    endtask

    initial begin
        bus.t_in     = 1'b1;
        bus.ev_ready = 1'b0;
        bus.clr_ovf  = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
